uart_alu_master: RTL and testbench

UART_ALU_MASTER -- requirements
Module: uart_alu_master

---
 rtl/uart_alu_master_pkg.sv | 19 +
 rtl/uart_alu_master_if.sv | 33 +++
 rtl/uart_alu_master.sv | 118 +++++++++++
 tb/tb_uart_alu_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_master_pkg.sv
// Shared UART-ALU definitions: default widths and the master FSM state encoding.
package uart_alu_master_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OPCODE_SZ_DEF  = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_A   = 3'd1,
    ST_SEND_B   = 3'd2,
    ST_SEND_OP  = 3'd3,
    ST_WAIT_RES = 3'd4
  } alu_state_e;

  function automatic logic is_send_state(input alu_state_e s);
    return (s == ST_SEND_A) || (s == ST_SEND_B) || (s == ST_SEND_OP);
  endfunction

endpackage

// File: rtl/uart_alu_master_if.sv
// UART FIFO side of the ALU master: TX push path and first-word-fall-through RX pop path.
interface uart_alu_master_if
  import uart_alu_master_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  i_tx_full;
  logic                  i_rx_empty;
  logic [DATA_WIDTH-1:0] i_r_data;
  logic [DATA_WIDTH-1:0] o_w_data;
  logic                  o_wr_uart;
  logic                  o_rd_uart;

  modport master (
    input  i_tx_full,
    input  i_rx_empty,
    input  i_r_data,
    output o_w_data,
    output o_wr_uart,
    output o_rd_uart
  );

  modport slave (
    output i_tx_full,
    output i_rx_empty,
    output i_r_data,
    input  o_w_data,
    input  o_wr_uart,
    input  o_rd_uart
  );

endinterface

// File: rtl/uart_alu_master.sv
// Sends op_a, op_b, opcode over the UART TX FIFO, then waits (bounded) for one result byte.
//   state       | meaning
//   ST_IDLE     | waiting for i_start; operands latched on acceptance
//   ST_SEND_A   | pushing operand A (advances only on a push)
//   ST_SEND_B   | pushing operand B
//   ST_SEND_OP  | pushing zero-extended opcode
//   ST_WAIT_RES | popping result byte or counting toward timeout
module uart_alu_master
  import uart_alu_master_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OPCODE_SZ      = OPCODE_SZ_DEF,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_op_a,
  input  logic [DATA_WIDTH-1:0] i_op_b,
  input  logic [OPCODE_SZ-1:0]  i_op_code,
  uart_alu_master_if.master     uart,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_valid,
  output logic                  o_timeout,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  alu_state_e            state;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic [OPCODE_SZ-1:0]  op_code_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [DATA_WIDTH-1:0] send_byte;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  push;
  logic                  pop;
  logic                  cnt_last;

  // Outside the send states the TX data bus keeps showing the last byte presented.
  always_comb begin
    send_byte = w_data_q;
    case (state)
      ST_SEND_A:  send_byte = op_a_q;
      ST_SEND_B:  send_byte = op_b_q;
      ST_SEND_OP: send_byte = DATA_WIDTH'(op_code_q);
      default:    send_byte = w_data_q;
    endcase
  end

  assign push     = is_send_state(state) && !uart.i_tx_full;
  assign pop      = (state == ST_WAIT_RES) && !uart.i_rx_empty;
  assign cnt_last = (wait_cnt == CNT_LAST);

  assign uart.o_wr_uart = push;
  assign uart.o_rd_uart = pop;
  assign uart.o_w_data  = send_byte;
  assign o_busy         = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      w_data_q  <= '0;
      wait_cnt  <= '0;
      o_result  <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      if (is_send_state(state)) begin
        w_data_q <= send_byte;
      end
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            op_a_q    <= i_op_a;
            op_b_q    <= i_op_b;
            op_code_q <= i_op_code;
            state     <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          if (push) state <= ST_SEND_B;
        end
        ST_SEND_B: begin
          if (push) state <= ST_SEND_OP;
        end
        ST_SEND_OP: begin
          if (push) begin
            wait_cnt <= '0;
            state    <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          // A result arriving on the last allowed cycle still counts as a result.
          if (pop) begin
            o_result <= uart.i_r_data;
            o_valid  <= 1'b1;
            state    <= ST_IDLE;
          end else if (cnt_last) begin
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_master.sv
// Directed bench for uart_alu_master: byte order, TX back-pressure, timeout edge, reset abort.
module tb_uart_alu_master;
  import uart_alu_master_pkg::*;

  localparam int DW = 8;
  localparam int OS = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic [OS-1:0] op_code = '0;
  logic [DW-1:0] result;
  logic          valid;
  logic          timeout;
  logic          busy;

  uart_alu_master_if #(.DATA_WIDTH(DW)) uart_bus ();

  uart_alu_master #(
    .DATA_WIDTH(DW),
    .OPCODE_SZ(OS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_start(start),
    .i_op_a(op_a),
    .i_op_b(op_b),
    .i_op_code(op_code),
    .uart(uart_bus),
    .o_result(result),
    .o_valid(valid),
    .o_timeout(timeout),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event recorder, sampled on the falling edge.
  int       rel_cyc = -1;
  bit       mon_en = 1'b0;
  int       n_push, n_rd, n_valid, n_to;
  logic [7:0] push_data [16];
  int       push_cyc [16];
  int       rd_cyc, valid_cyc, to_cyc;
  logic [7:0] valid_res;
  bit       rx_popped;
  int       snap_cyc = -1;
  logic [20:0] snap;
  logic     busy_log [64];

  always @(negedge clk) begin
    if (mon_en) begin
      if (uart_bus.o_wr_uart) begin
        if (n_push < 16) begin
          push_data[n_push] = uart_bus.o_w_data;
          push_cyc[n_push]  = rel_cyc;
        end
        n_push++;
      end
      if (uart_bus.o_rd_uart) begin
        n_rd++;
        rd_cyc = rel_cyc;
        rx_popped = 1'b1;
      end
      if (valid) begin
        n_valid++;
        valid_cyc = rel_cyc;
        valid_res = result;
      end
      if (timeout) begin
        n_to++;
        to_cyc = rel_cyc;
      end
      if (rel_cyc >= 0 && rel_cyc < 64) busy_log[rel_cyc] = busy;
      if (rel_cyc == snap_cyc)
        snap = {busy, uart_bus.o_wr_uart, uart_bus.o_rd_uart, valid, timeout, result, uart_bus.o_w_data};
    end
  end

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input int full_lo, input int full_hi, input int rx_at,
                         input logic [7:0] rx_byte, input int restart_at,
                         input int reset_at, input int snap_at, input int ncyc);
    n_push = 0; n_rd = 0; n_valid = 0; n_to = 0;
    rd_cyc = -1; valid_cyc = -1; to_cyc = -1; valid_res = '0;
    rx_popped = 1'b0;
    snap_cyc = snap_at;
    snap = '1;
    for (int i = 0; i < 16; i++) begin
      push_data[i] = '0;
      push_cyc[i] = -1;
    end
    for (int i = 0; i < 64; i++) busy_log[i] = 1'bx;
    op_a = a; op_b = b; op_code = op;
    for (int r = 0; r < ncyc; r++) begin
      @(posedge clk);
      #1;
      rel_cyc = r;
      mon_en = 1'b1;
      start = (r == 0) || (r == restart_at);
      uart_bus.i_tx_full  = (r >= full_lo) && (r <= full_hi);
      uart_bus.i_rx_empty = !((r >= rx_at) && !rx_popped);
      uart_bus.i_r_data   = rx_byte;
      rst = (r == reset_at);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rel_cyc = -1;
    start = 1'b0;
    rst = 1'b0;
    uart_bus.i_tx_full  = 1'b0;
    uart_bus.i_rx_empty = 1'b1;
  endtask

  initial begin
    uart_bus.i_tx_full  = 1'b0;
    uart_bus.i_rx_empty = 1'b0;
    uart_bus.i_r_data   = 8'hEE;
    start = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",    busy, 0);
    check_eq("rst_wr",      uart_bus.o_wr_uart, 0);
    check_eq("rst_rd",      uart_bus.o_rd_uart, 0);
    check_eq("rst_valid",   valid, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_result",  result, 0);
    check_eq("rst_wdata",   uart_bus.o_w_data, 0);
    start = 1'b0;
    rst = 1'b0;
    uart_bus.i_rx_empty = 1'b1;

    // Basic transaction, result on cycle 10.
    run_txn(8'h05, 8'h03, 6'h20, 99, 99, 10, 8'h08, -1, -1, -1, 14);
    check_eq("t1_npush",  n_push, 3);
    check_eq("t1_p0",     {push_cyc[0][7:0], push_data[0]}, {8'd1, 8'h05});
    check_eq("t1_p1",     {push_cyc[1][7:0], push_data[1]}, {8'd2, 8'h03});
    check_eq("t1_p2",     {push_cyc[2][7:0], push_data[2]}, {8'd3, 8'h20});
    check_eq("t1_rd",     {n_rd[7:0], rd_cyc[7:0]}, {8'd1, 8'd10});
    check_eq("t1_valid",  {n_valid[7:0], valid_cyc[7:0], valid_res}, {8'd1, 8'd11, 8'h08});
    check_eq("t1_noto",   n_to, 0);
    check_eq("t1_busy",   {busy_log[4], busy_log[11]}, 2'b10);

    // TX full during cycles 2..5.
    run_txn(8'h05, 8'h03, 6'h20, 2, 5, 12, 8'h5A, -1, -1, -1, 16);
    check_eq("t2_npush",  n_push, 3);
    check_eq("t2_p0",     {push_cyc[0][7:0], push_data[0]}, {8'd1, 8'h05});
    check_eq("t2_p1",     {push_cyc[1][7:0], push_data[1]}, {8'd6, 8'h03});
    check_eq("t2_p2",     {push_cyc[2][7:0], push_data[2]}, {8'd7, 8'h20});
    check_eq("t2_valid",  {n_valid[7:0], valid_cyc[7:0], valid_res}, {8'd1, 8'd13, 8'h5A});

    // No result: timeout 16 cycles after WAIT_RES entry (cycle 4).
    run_txn(8'h11, 8'h22, 6'h3F, 99, 99, 1000, 8'h99, -1, -1, -1, 24);
    check_eq("t3_p2",      {push_cyc[2][7:0], push_data[2]}, {8'd3, 8'h3F});
    check_eq("t3_to",      {n_to[7:0], to_cyc[7:0]}, {8'd1, 8'd20});
    check_eq("t3_novalid", n_valid, 0);
    check_eq("t3_nord",    n_rd, 0);
    check_eq("t3_result",  result, 8'h5A);
    check_eq("t3_busy",    {busy_log[19], busy_log[20]}, 2'b10);

    // Result arrives exactly on the last counted cycle: read wins.
    run_txn(8'h12, 8'h34, 6'h05, 99, 99, 19, 8'hC3, -1, -1, -1, 24);
    check_eq("t4_rd",     {n_rd[7:0], rd_cyc[7:0]}, {8'd1, 8'd19});
    check_eq("t4_valid",  {n_valid[7:0], valid_cyc[7:0], valid_res}, {8'd1, 8'd20, 8'hC3});
    check_eq("t4_noto",   n_to, 0);

    // Reset while in SEND_B.
    run_txn(8'hA1, 8'hB2, 6'h2C, 99, 99, 1000, 8'h00, -1, 2, 3, 8);
    check_eq("t5_npush",  n_push, 2);
    check_eq("t5_snap",   snap, 21'd0);
    check_eq("t5_idle",   busy_log[7], 0);

    // Fresh transaction after reset.
    run_txn(8'hFF, 8'h00, 6'h01, 99, 99, 5, 8'h77, -1, -1, -1, 10);
    check_eq("t6_npush",  n_push, 3);
    check_eq("t6_p0",     {push_cyc[0][7:0], push_data[0]}, {8'd1, 8'hFF});
    check_eq("t6_p2",     {push_cyc[2][7:0], push_data[2]}, {8'd3, 8'h01});
    check_eq("t6_valid",  {n_valid[7:0], valid_cyc[7:0], valid_res}, {8'd1, 8'd6, 8'h77});

    // i_start during WAIT_RES is ignored.
    run_txn(8'h0A, 8'h0B, 6'h0C, 99, 99, 9, 8'h42, 6, -1, -1, 14);
    check_eq("t7_npush",  n_push, 3);
    check_eq("t7_valid",  {n_valid[7:0], valid_cyc[7:0], valid_res}, {8'd1, 8'd10, 8'h42});

    // i_start in the o_valid cycle is accepted; second run times out.
    run_txn(8'h31, 8'h32, 6'h33, 99, 99, 10, 8'h64, 11, -1, -1, 34);
    check_eq("t8_npush",  n_push, 6);
    check_eq("t8_p3",     {push_cyc[3][7:0], push_data[3]}, {8'd12, 8'h31});
    check_eq("t8_p5",     {push_cyc[5][7:0], push_data[5]}, {8'd14, 8'h33});
    check_eq("t8_valid",  {n_valid[7:0], valid_cyc[7:0]}, {8'd1, 8'd11});
    check_eq("t8_to",     {n_to[7:0], to_cyc[7:0]}, {8'd1, 8'd31});
    check_eq("t8_result", result, 8'h64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
